arith_dispatcher: RTL and testbench
===================================

Name: arith_dispatcher

Overview:
- Request sequencer that sits directly upstream of the divider and its add/sub/mul peers.
- Accepts one arithmetic request (opcode plus two 64-bit operands) over a valid/ready interface and drives the shared operand bus.
- Asserts exactly one unit `start` once every other unit reports not-working, holds it for a fixed settle window, then captures that unit's result.
- Returns the result to the requester over a valid/ready response interface.

Parameters:
- DATA_W, 64: operand/result width.
- SETTLE_CYC, 2: cycles `start` is held before the result is sampled (1..15).
- ARB_TIMEOUT, 16: maximum cycles to wait in ARB for other units to go idle (1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  dispatcher can accept a request.
- req_op  in  2  opcode: 0=add, 1=sub, 2=mul, 3=div.
- req_a  in  DATA_W  operand a.
- req_b  in  DATA_W  operand b.
- unit_a  out  DATA_W  registered operand a, broadcast to all units.
- unit_b  out  DATA_W  registered operand b, broadcast to all units.
- start_vec  out  4  one-hot start per unit; bit index = opcode.
- working_vec  in  4  per-unit `working` outputs; bit index = opcode.
- res_add  in  DATA_W  result from the add unit.
- res_sub  in  DATA_W  result from the sub unit.
- res_mul  in  DATA_W  result from the mul unit.
- res_div  in  DATA_W  result from the div unit.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  DATA_W  captured result.
- resp_op  out  2  opcode of the completed request.
- resp_err  out  1  1 = divide-by-zero or arbitration timeout; resp_data forced to 0.

Behaviour:
- Reset (async, active-high): state=IDLE; req_ready=1; start_vec=0; resp_valid=0; resp_data=0; resp_op=0; resp_err=0; unit_a=0; unit_b=0; counters=0. Reset mid-operation aborts immediately; no response is produced for the aborted request.
- State IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_a→unit_a, req_b→unit_b, req_op→op_q; clear the timeout counter; go to ARB.
- State ARB:
  - req_ready=0; start_vec=0.
  - If working_vec with bit op_q masked off is 0: go to EXEC, clear the settle counter.
  - Otherwise increment the timeout counter. When it reaches ARB_TIMEOUT-1 without the units going idle: resp_err=1, resp_data=0, go to RESP.
- State EXEC:
  - start_vec = one-hot(op_q), held high for exactly SETTLE_CYC cycles.
  - On the last settle cycle, register the selected res_* into resp_data and go to RESP.
  - If op_q=div and unit_b=0: resp_err=1 and resp_data=0, regardless of res_div.
  - start_vec deasserts on the cycle RESP is entered.
- State RESP:
  - resp_valid=1; resp_data, resp_op and resp_err are stable while resp_valid&&!resp_ready.
  - On resp_ready: resp_valid=0 next cycle, go to IDLE. The next request is accepted on the cycle after IDLE is re-entered; there is no accept-in-same-cycle bypass.
- Latency (no contention): accept edge T0 → ARB at T1 → EXEC from T2 to T2+SETTLE_CYC-1 → resp_valid at T2+SETTLE_CYC (4 cycles with defaults).
- Simultaneous events:
  - req_valid while not IDLE is ignored, because req_ready=0.
  - In ARB, a working_vec bit going low on the same cycle the timeout expires gives the idle condition priority: go to EXEC.
- Invariants:
  - start_vec is never multi-hot.
  - start_vec is 0 in IDLE, ARB and RESP.
  - The unit_a/unit_b outputs change only on an accept edge.

Decomposition:
- Shared package arith_pkg holds:
  - the opcode enum (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3);
  - the state enum (IDLE, ARB, EXEC, RESP);
  - the DATA_W default.
- One natural sub-module: arith_result_mux, a combinational 4:1 result select plus div-by-zero error generation. The FSM, counters and registers stay in arith_dispatcher.

Test Plan:
- Reset release, then req op=div, a=100, b=7, working_vec=0 → start_vec=4'b1000 for 2 cycles; resp_valid 4 cycles after accept; resp_data=14; resp_err=0; resp_op=3.
- req op=div, a=55, b=0 → resp_err=1, resp_data=0; start_vec still pulsed 2 cycles.
- req op=add, a=3, b=4, with working_vec[2]=1 for 5 cycles then 0 → start_vec=4'b0001 only after bit 2 drops; resp_data=7; latency 9 cycles.
- req op=mul with working_vec[0]=1 held forever → resp_err=1, resp_data=0 after ARB_TIMEOUT cycles; start_vec never asserted.
- resp_ready held low 6 cycles after resp_valid → resp_data/resp_op/resp_err stable; req_ready=0 throughout; a back-to-back request is accepted only the cycle after the handshake.
- Assert rst during EXEC → start_vec=0 and resp_valid=0 immediately (asynchronous); req_ready=1 on the first clock after release; no spurious response.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types for the arithmetic request dispatcher and its result path.
// Opcode values double as bit indices into the per-unit start/working vectors.
package arith_pkg;

  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/arith_result_mux.sv
// Selects the result of the unit addressed by op and flags divide-by-zero.
// A flagged error forces the data to zero so garbage from the divider never escapes.
module arith_result_mux
  import arith_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [DATA_W-1:0] res_add,
  input  logic [DATA_W-1:0] res_sub,
  input  logic [DATA_W-1:0] res_mul,
  input  logic [DATA_W-1:0] res_div,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  always_comb begin
    data = '0;
    err  = (op == OP_DIV) && (operand_b == '0);
    case (op)
      OP_ADD:  data = res_add;
      OP_SUB:  data = res_sub;
      OP_MUL:  data = res_mul;
      OP_DIV:  data = res_div;
      default: data = '0;
    endcase
    if (err) data = '0;
  end

endmodule

// File: rtl/arith_dispatcher.sv
// Sequences one arithmetic request at a time onto the shared add/sub/mul/div units:
// waits for the other units to idle, pulses the selected start, captures the result.
//
//   state | meaning
//   IDLE  | ready for a request; operands and opcode latched on accept
//   ARB   | waiting for every other unit to drop working, bounded by ARB_TIMEOUT
//   EXEC  | start held on the selected unit for SETTLE_CYC cycles, result captured at the end
//   RESP  | response presented until the consumer takes it
module arith_dispatcher
  import arith_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SETTLE_CYC  = 2,
  parameter int ARB_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  output logic [3:0]        start_vec,
  input  logic [3:0]        working_vec,
  input  logic [DATA_W-1:0] res_add,
  input  logic [DATA_W-1:0] res_sub,
  input  logic [DATA_W-1:0] res_mul,
  input  logic [DATA_W-1:0] res_div,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [1:0]        resp_op,
  output logic              resp_err
);

  state_e            state;
  logic [1:0]        op_q;
  logic [3:0]        settle_cnt;
  logic [7:0]        arb_cnt;
  logic [3:0]        start_q;
  logic [3:0]        others_busy;
  logic [DATA_W-1:0] mux_data;
  logic              mux_err;

  // The selected unit's own working bit is ignored; only contention from peers blocks.
  assign others_busy = working_vec & ~(4'b0001 << op_q);
  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign start_vec   = start_q;

  arith_result_mux #(
    .DATA_W (DATA_W)
  ) u_result_mux (
    .op        (op_q),
    .operand_b (unit_b),
    .res_add   (res_add),
    .res_sub   (res_sub),
    .res_mul   (res_mul),
    .res_div   (res_div),
    .data      (mux_data),
    .err       (mux_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= 2'd0;
      settle_cnt <= 4'd0;
      arb_cnt    <= 8'd0;
      start_q    <= 4'd0;
      unit_a     <= '0;
      unit_b     <= '0;
      resp_data  <= '0;
      resp_op    <= 2'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            unit_a  <= req_a;
            unit_b  <= req_b;
            op_q    <= req_op;
            arb_cnt <= 8'd0;
            state   <= ARB;
          end
        end
        ARB: begin
          // Peers going idle wins over a timeout expiring on the same cycle.
          if (others_busy == 4'd0) begin
            settle_cnt <= 4'd0;
            start_q    <= 4'b0001 << op_q;
            state      <= EXEC;
          end else if (arb_cnt == 8'(ARB_TIMEOUT - 1)) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            resp_op   <= op_q;
            state     <= RESP;
          end else begin
            arb_cnt <= arb_cnt + 8'd1;
          end
        end
        EXEC: begin
          if (settle_cnt == 4'(SETTLE_CYC - 1)) begin
            start_q   <= 4'd0;
            resp_data <= mux_data;
            resp_err  <= mux_err;
            resp_op   <= op_q;
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_dispatcher.sv
// Scoreboard bench for arith_dispatcher: behavioural units answer from the operand bus,
// expected responses are queued at request time and compared when resp_valid appears.
module tb_arith_dispatcher;
  import arith_pkg::*;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'd0;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic [DW-1:0] unit_a, unit_b;
  logic [3:0]    start_vec;
  logic [3:0]    working_vec = 4'd0;
  logic [DW-1:0] res_add, res_sub, res_mul, res_div;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic [1:0]    resp_op;
  logic          resp_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    op;
    logic          err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  arith_dispatcher #(
    .DATA_W      (DW),
    .SETTLE_CYC  (2),
    .ARB_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .start_vec   (start_vec),
    .working_vec (working_vec),
    .res_add     (res_add),
    .res_sub     (res_sub),
    .res_mul     (res_mul),
    .res_div     (res_div),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_op     (resp_op),
    .resp_err    (resp_err)
  );

  // Behavioural units; the divider returns all-ones on b=0 so forcing to 0 is visible.
  assign res_add = unit_a + unit_b;
  assign res_sub = unit_a - unit_b;
  assign res_mul = unit_a * unit_b;
  assign res_div = (unit_b == '0) ? '1 : unit_a / unit_b;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones(start_vec) > 1) begin
        failures++;
        $display("FAIL start_onehot: start_vec=%b required at most one bit", start_vec);
      end
      checks++;
      if (resp_valid && start_vec !== 4'd0) begin
        failures++;
        $display("FAIL start_in_resp: start_vec=%b required 0000", start_vec);
      end
    end
  end

  function automatic exp_t model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.op = op;
    e.err = 1'b0;
    case (op)
      2'd0: e.data = a + b;
      2'd1: e.data = a - b;
      2'd2: e.data = a * b;
      default: begin
        if (b == '0) begin
          e.err = 1'b1;
          e.data = '0;
        end else begin
          e.data = a / b;
        end
      end
    endcase
    return e;
  endfunction

  function automatic void push_exp(input logic [DW-1:0] d, input logic [1:0] op, input logic err);
    exp_t e;
    e.data = d;
    e.op = op;
    e.err = err;
    sb.push_back(e);
  endfunction

  // Presents a request at a negedge while IDLE; returns at the negedge of the ARB cycle.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat, input logic [3:0] exp_start, input int exp_sc, input int hold);
    int lat;
    int sc;
    bit bad_start;
    exp_t e;
    logic [DW-1:0] d0;
    logic [1:0] o0;
    logic e0;
    lat = 1;
    sc = 0;
    bad_start = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin
      if (start_vec !== 4'd0) begin
        sc++;
        if (start_vec !== exp_start) bad_start = 1;
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL resp_timeout: resp_valid=%b after %0d cycles required 1", resp_valid, lat);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL latency: got %0d cycles required %0d", lat, exp_lat);
    end
    checks++;
    if (sc != exp_sc || bad_start) begin
      failures++;
      $display("FAIL start_pulse: %0d cycles (wrong_bits=%0d) required %0d cycles of %b", sc, bad_start, exp_sc, exp_start);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty: response with no expectation queued");
    end else begin
      e = sb.pop_front();
      if (resp_data !== e.data || resp_op !== e.op || resp_err !== e.err) begin
        failures++;
        $display("FAIL resp_fields: data=%0h op=%0d err=%b required data=%0h op=%0d err=%b",
                 resp_data, resp_op, resp_err, e.data, e.op, e.err);
      end
    end
    d0 = resp_data;
    o0 = resp_op;
    e0 = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== d0 || resp_op !== o0 || resp_err !== e0) begin
        failures++;
        $display("FAIL hold_stable: valid=%b ready=%b data=%0h op=%0d err=%b required 1 0 %0h %0d %b",
                 resp_valid, req_ready, resp_data, resp_op, resp_err, d0, o0, e0);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL handshake: resp_valid=%b req_ready=%b required 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (start_vec !== 4'd0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_data !== '0 ||
        resp_op !== 2'd0 || resp_err !== 1'b0 || unit_a !== '0 || unit_b !== '0) begin
      failures++;
      $display("FAIL reset_values: start=%b rv=%b rr=%b data=%0h op=%0d err=%b a=%0h b=%0h required all idle/zero",
               start_vec, resp_valid, req_ready, resp_data, resp_op, resp_err, unit_a, unit_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: req_ready=%b resp_valid=%b required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_div();
    working_vec = 4'b1000;
    issue(2'd3, 64'd100, 64'd7);
    checks++;
    if (unit_a !== 64'd100 || unit_b !== 64'd7) begin
      failures++;
      $display("FAIL operand_bus: unit_a=%0d unit_b=%0d required 100 7", unit_a, unit_b);
    end
    push_exp(64'd14, 2'd3, 1'b0);
    wait_resp(4, 4'b1000, 2, 0);
    working_vec = 4'd0;
  endtask

  task automatic test_div_zero();
    issue(2'd3, 64'd55, 64'd0);
    push_exp(64'd0, 2'd3, 1'b1);
    wait_resp(4, 4'b1000, 2, 0);
  endtask

  task automatic test_contention();
    issue(2'd0, 64'd3, 64'd4);
    working_vec = 4'b0100;
    fork
      begin
        repeat (5) @(negedge clk);
        working_vec = 4'd0;
      end
    join_none
    push_exp(64'd7, 2'd0, 1'b0);
    wait_resp(9, 4'b0001, 2, 0);
  endtask

  task automatic test_timeout();
    working_vec = 4'b0001;
    issue(2'd2, 64'd6, 64'd7);
    push_exp(64'd0, 2'd2, 1'b1);
    wait_resp(17, 4'b0000, 0, 0);
    working_vec = 4'd0;
  endtask

  task automatic test_back_to_back();
    issue(2'd1, 64'd50, 64'd8);
    push_exp(64'd42, 2'd1, 1'b0);
    req_valid = 1'b1;
    req_op = 2'd2;
    req_a = 64'd9;
    req_b = 64'd11;
    wait_resp(4, 4'b0010, 2, 6);
    checks++;
    if (unit_a !== 64'd50 || unit_b !== 64'd8) begin
      failures++;
      $display("FAIL no_early_accept: unit_a=%0d unit_b=%0d required 50 8", unit_a, unit_b);
    end
    push_exp(64'd99, 2'd2, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (unit_a !== 64'd9 || unit_b !== 64'd11 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: unit_a=%0d unit_b=%0d req_ready=%b required 9 11 0", unit_a, unit_b, req_ready);
    end
    wait_resp(4, 4'b0100, 2, 0);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [DW-1:0] a, b;
    for (int n = 0; n < 6; n++) begin
      op = 2'($urandom_range(0, 3));
      a = {32'd0, $urandom};
      b = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(1, 1000));
      issue(op, a, b);
      sb.push_back(model(op, a, b));
      wait_resp(4, 4'b0001 << op, 2, $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_exec();
    int spurious;
    issue(2'd2, 64'd5, 64'd6);
    @(negedge clk);
    checks++;
    if (start_vec !== 4'b0100) begin
      failures++;
      $display("FAIL exec_start: start_vec=%b required 0100", start_vec);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (start_vec !== 4'd0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: start=%b resp_valid=%b req_ready=%b required 0000 0 1", start_vec, resp_valid, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready: req_ready=%b required 1", req_ready);
    end
    spurious = 0;
    repeat (8) begin
      if (resp_valid !== 1'b0 || start_vec !== 4'd0) spurious++;
      @(negedge clk);
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL spurious_resp: %0d active cycles after abort required 0", spurious);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d queued required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_div_zero();
    test_contention();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
